// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: synchronizes the codec's BCLK/ADCLRCK/ADCDAT into clk and deserializes
// 16-bit stereo frames into left/right pairs. Pairs go out through a one-pair valid/ready buffer.
module i2s_adc_receiver #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              active
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_WAIT_LR = 2'd3;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizers. The three lines share one chain of identical
    // depth, so the data bit stays aligned with the BCLK edge it belongs to.
    // ------------------------------------------------------------------
    logic [2:0]                     aud_in;
    logic [SYNC_STAGES-1:0][2:0]    sync_q;
    logic [SYNC_STAGES-1:0][2:0]    sync_d;
    logic                           bclk_prev_q;
    logic                           bclk_prev_d;
    logic                           lrck_prev_q;
    logic                           lrck_prev_d;

    logic bclk_s;
    logic lrck_s;
    logic dat_s;
    logic bclk_rise;
    logic lr_fall;
    logic lr_rise;

    assign aud_in = {AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT};

    always_comb begin
        sync_d[0] = aud_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign bclk_s = sync_q[SYNC_STAGES-1][2];
    assign lrck_s = sync_q[SYNC_STAGES-1][1];
    assign dat_s  = sync_q[SYNC_STAGES-1][0];

    assign bclk_prev_d = bclk_s;
    assign lrck_prev_d = lrck_s;

    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign lr_fall   = ~lrck_s & lrck_prev_q;
    assign lr_rise   = lrck_s & ~lrck_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bclk_prev_q <= bclk_prev_d;
            lrck_prev_q <= lrck_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame deserializer
    // ------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              chan_q;
    logic              chan_d;
    logic [CNT_W-1:0]  bitcnt_q;
    logic [CNT_W-1:0]  bitcnt_d;
    logic [DATA_W-2:0] shift_q;
    logic [DATA_W-2:0] shift_d;
    logic [DATA_W-1:0] hold_l_q;
    logic [DATA_W-1:0] hold_l_d;
    logic              left_ok_q;
    logic              left_ok_d;

    logic [DATA_W-1:0] word;
    logic              pair_done;

    // The word including the bit arriving this cycle; only meaningful on bclk_rise.
    assign word = {shift_q, dat_s};

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        hold_l_d  = hold_l_q;
        left_ok_d = left_ok_q;
        pair_done = 1'b0;

        if (!init_done) begin
            state_d   = ST_IDLE;
            bitcnt_d  = '0;
            shift_d   = '0;
            left_ok_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (lr_fall) begin
                state_d   = ST_SKIP;
                chan_d    = CH_L;
                left_ok_d = 1'b0;
            end
        end else begin
            // An LRCK edge always wins over a coincident BCLK edge.
            if (lr_fall) begin
                state_d   = ST_SKIP;
                chan_d    = CH_L;
                left_ok_d = 1'b0;
            end else if (lr_rise) begin
                state_d   = ST_SKIP;
                chan_d    = CH_R;
                // Only a fully received left word may pair with the coming right word.
                left_ok_d = left_ok_q && (state_q == ST_WAIT_LR) && (chan_q == CH_L);
            end else if (bclk_rise) begin
                case (state_q)
                    ST_SKIP: begin
                        state_d  = ST_SHIFT;
                        bitcnt_d = '0;
                    end
                    ST_SHIFT: begin
                        shift_d  = word[DATA_W-2:0];
                        bitcnt_d = bitcnt_q + CNT_ONE;
                        if (bitcnt_q == CNT_LAST) begin
                            state_d = ST_WAIT_LR;
                            if (chan_q == CH_L) begin
                                hold_l_d  = word;
                                left_ok_d = 1'b1;
                            end else begin
                                pair_done = left_ok_q;
                                left_ok_d = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            chan_q    <= CH_L;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            hold_l_q  <= '0;
            left_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            hold_l_q  <= hold_l_d;
            left_ok_q <= left_ok_d;
        end
    end

    // ------------------------------------------------------------------
    // One-pair output buffer and sticky overrun flag
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sample_l_q;
    logic [DATA_W-1:0] sample_l_d;
    logic [DATA_W-1:0] sample_r_q;
    logic [DATA_W-1:0] sample_r_d;
    logic              sample_valid_q;
    logic              sample_valid_d;
    logic              overrun_q;
    logic              overrun_d;

    always_comb begin
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = overrun_q & ~overrun_clr;

        if (sample_valid_q && sample_ready) begin
            sample_valid_d = 1'b0;
        end

        // A new pair may replace one being consumed this cycle; otherwise it is dropped.
        if (pair_done) begin
            if (!sample_valid_q || sample_ready) begin
                sample_l_d     = hold_l_q;
                sample_r_d     = word;
                sample_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign active       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives I2S frames at BCLK = clk/8 and scoreboards delivered pairs
// against a frame-level model (full L and R words while enabled -> one pair, unless buffer busy).
module tb_i2s_adc_receiver;

    localparam int DATA_W    = 16;
    localparam int HALF_CLKS = 4;
    localparam int EV_NONE   = 0;
    localparam int EV_INIT   = 1;
    localparam int EV_RESET  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              init_done;
    logic              AUD_BCLK;
    logic              AUD_ADCLRCK;
    logic              AUD_ADCDAT;
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              overrun_clr;
    logic              active;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic        exp_overrun;

    always #5 clk = ~clk;

    i2s_adc_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .init_done    (init_done),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .active       (active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   sample_valid, 1'b0);
        check({tag, "_l"},       sample_l, 16'h0000);
        check({tag, "_r"},       sample_r, 16'h0000);
        check({tag, "_overrun"}, overrun, 1'b0);
        check({tag, "_active"},  active, 1'b0);
    endtask

    // Monitor: a pair transfers on the next posedge when valid && ready are seen here.
    initial begin
        logic [31:0] exp_pair;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && sample_valid && sample_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got %h_%h, expected no pair", sample_l, sample_r);
                end else begin
                    exp_pair = sb_q.pop_front();
                    check("pair", {sample_l, sample_r}, exp_pair);
                    $display("pair L=%h R=%h expected %h_%h", sample_l, sample_r,
                             exp_pair[31:16], exp_pair[15:0]);
                end
            end
        end
    end

    // One LRCK half: slot 0 carries the I2S one-bit delay, slots 1..DATA_W carry the word MSB first.
    task automatic send_half(input logic lr, input logic [DATA_W-1:0] w, input int nslots,
                             input int ev_slot, input int ev_kind);
        logic d;
        for (int s = 0; s < nslots; s++) begin
            d = (s >= 1 && s <= DATA_W) ? w[DATA_W-s] : 1'b0;
            @(negedge clk);
            AUD_BCLK    = 1'b0;
            AUD_ADCLRCK = lr;
            AUD_ADCDAT  = d;
            if (s == ev_slot && ev_kind == EV_INIT) begin
                init_done = 1'b1;
            end
            if (s == ev_slot && ev_kind == EV_RESET) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check_reset_outputs("midreset");
                sb_q.delete();
                exp_overrun = 1'b0;
            end
            repeat (HALF_CLKS) @(negedge clk);
            AUD_BCLK = 1'b1;
            repeat (HALF_CLKS - 1) @(negedge clk);
        end
    endtask

    // Frame-level model: a pair results when enabled at the left edge and both halves are full length.
    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input int lslots, input int rslots);
        logic expect_pair;
        expect_pair = init_done && (lslots >= DATA_W + 1) && (rslots >= DATA_W + 1);
        send_half(1'b0, l, lslots, -1, EV_NONE);
        if (expect_pair) begin
            if (sb_q.size() > 0 && !sample_ready) begin
                exp_overrun = 1'b1;
            end else begin
                sb_q.push_back({l, r});
            end
        end
        send_half(1'b1, r, rslots, -1, EV_NONE);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d pairs outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        reset        = 1'b1;
        init_done    = 1'b0;
        AUD_BCLK     = 1'b0;
        AUD_ADCLRCK  = 1'b1;
        AUD_ADCDAT   = 1'b0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        exp_overrun  = 1'b0;

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic frame
        init_done = 1'b1;
        send_frame(16'hA5C3, 16'h1234, 20, 20);
        drain("t1_drain");
        check("t1_overrun", overrun, exp_overrun);
        check("t1_active", active, 1'b1);

        // Disabled stream, then enable mid-right channel
        @(negedge clk);
        init_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_frame(DATA_W'($urandom), DATA_W'($urandom), 20, 20);
            check("t2_active_off", active, 1'b0);
        end
        check("t2_valid_off", sample_valid, 1'b0);
        send_half(1'b0, DATA_W'($urandom), 20, -1, EV_NONE);
        send_half(1'b1, DATA_W'($urandom), 20, 8, EV_INIT);
        check("t2_active_wait", active, 1'b0);
        send_frame(16'hBEEF, 16'hCAFE, 20, 20);
        drain("t2_drain");

        // Back-pressure and overrun
        sample_ready = 1'b0;
        send_frame(16'h0001, 16'h0002, 20, 20);
        send_frame(16'h0003, 16'h0004, 20, 20);
        repeat (10) @(negedge clk);
        check("t3_valid_held", sample_valid, 1'b1);
        check("t3_hold_l", sample_l, 16'h0001);
        check("t3_hold_r", sample_r, 16'h0002);
        check("t3_overrun_set", overrun, exp_overrun);
        sample_ready = 1'b1;
        drain("t3_drain");
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        exp_overrun = 1'b0;
        #1;
        check("t3_overrun_clr", overrun, exp_overrun);
        check("t3_valid_drop", sample_valid, 1'b0);

        // Short left word, then a good frame
        send_frame(DATA_W'($urandom), DATA_W'($urandom), 11, 20);
        send_frame(16'h7FFF, 16'h8000, 20, 20);
        drain("t4_drain");

        // Reset pulse mid-SHIFT, then a good frame
        send_half(1'b0, 16'h1357, 20, 6, EV_RESET);
        send_half(1'b1, 16'h2468, 20, -1, EV_NONE);
        send_frame(16'h0F0F, 16'hF0F0, 20, 20);
        drain("t5_drain");

        // Random streaming
        for (int i = 0; i < 100; i++) begin
            send_frame(DATA_W'($urandom), DATA_W'($urandom),
                       $urandom_range(DATA_W + 1, 24), $urandom_range(DATA_W + 1, 24));
        end
        drain("t6_drain");
        check("t6_overrun", overrun, exp_overrun);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
